imem_loader: RTL and testbench

Instruction-memory program loader for the pipelined RISC-V core. Accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and drives the core's instruction-memory write port (`InstrWrite`, `WriteInst`, `WriteAdress`). Holds the core in reset until a complete image is written, then releases it. Sits between a byte source (UART receiver or bench driver) and `top`.

---
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_loader.sv | 172 +++++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a byte source and imem_loader.
// The master drives valid/data; the slave (the loader) drives ready.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory and holds the core in reset until done.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         InstrWrite,
  output logic [31:0]  WriteInst,
  output logic [31:0]  WriteAdress,
  output logic         core_reset,
  output logic         done,
  output logic         error
);
  localparam int unsigned CNT_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_t;

  // State entered once the image body is complete (or the count is zero).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_LAST = S_CSUM;
`else
  localparam state_t S_LAST = S_DONE;
`endif

  state_t              state, state_n;
  logic [CNT_W-1:0]    count, count_n;
  logic [CNT_W-1:0]    k, k_n;
  logic [1:0]          b, b_n;
  logic [WORD_W-1:0]   word, word_n;
  logic [7:0]          csum, csum_n;
  logic                ready_q, ready_n;
  logic                instr_write_n, core_reset_n, done_n, error_n;
  logic [WORD_W-1:0]   write_inst_n, write_addr_n;
  logic                xfer;
  logic [CNT_W-1:0]    hdr;

  assign bus.byte_ready = ready_q;
  assign xfer           = bus.byte_valid & ready_q;
  assign hdr            = {bus.byte_data, count[7:0]};

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_n       = state;
    count_n       = count;
    k_n           = k;
    b_n           = b;
    word_n        = word;
    csum_n        = csum;
    ready_n       = 1'b0;
    instr_write_n = 1'b0;
    write_inst_n  = WriteInst;
    write_addr_n  = WriteAdress;
    core_reset_n  = 1'b1;
    done_n        = 1'b0;
    error_n       = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n = S_LEN0;
          count_n = '0;
          csum_n  = '0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          count_n[7:0] = bus.byte_data;
          csum_n       = csum ^ bus.byte_data;
          state_n      = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          count_n = hdr;
          csum_n  = csum ^ bus.byte_data;
          k_n     = '0;
          b_n     = '0;
          if (hdr == '0)                    state_n = S_LAST;
          else if (32'(hdr) > MAX_WORDS)    state_n = S_ERR;
          else                              state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_n[{b, 3'b000} +: 8] = bus.byte_data;
          csum_n = csum ^ bus.byte_data;
          if (b == 2'd3) state_n = S_WRITE;
          else           b_n     = b + 2'd1;
        end
      end
      S_WRITE: begin
        if (k + 16'd1 == count) begin
          state_n = S_LAST;
        end else begin
          k_n     = k + 16'd1;
          b_n     = '0;
          state_n = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_n = (bus.byte_data == csum) ? S_DONE : S_ERR;
      end
`endif
      default: state_n = S_IDLE;
    endcase

    // Ready follows the next state, but stays low for one cycle after a start.
    case (state_n)
      S_LEN0, S_LEN1, S_DATA: ready_n = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                 ready_n = 1'b1;
`endif
      default:                ready_n = 1'b0;
    endcase
    if (state == S_IDLE || state == S_DONE || state == S_ERR) ready_n = 1'b0;

    // Write port and status reflect the state held during the previous cycle.
    if (state == S_WRITE) begin
      instr_write_n = 1'b1;
      write_inst_n  = word;
      write_addr_n  = BASE_ADDR + 32'({k, 2'b00});
    end
    core_reset_n = (state != S_DONE);
    done_n       = (state == S_DONE);
    error_n      = (state == S_ERR);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      k           <= '0;
      b           <= '0;
      word        <= '0;
      csum        <= '0;
      ready_q     <= 1'b0;
      InstrWrite  <= 1'b0;
      WriteInst   <= '0;
      WriteAdress <= BASE_ADDR;
      core_reset  <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      k           <= k_n;
      b           <= b_n;
      word        <= word_n;
      csum        <= csum_n;
      ready_q     <= ready_n;
      InstrWrite  <= instr_write_n;
      WriteInst   <= write_inst_n;
      WriteAdress <= write_addr_n;
      core_reset  <= core_reset_n;
      done        <= done_n;
      error       <= error_n;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random images checked against a stream-level model.
// Supports builds with or without LOADER_CHECKSUM_EN.
module tb_imem_loader;
  localparam logic [31:0] TB_BASE = 32'h100;
  localparam int unsigned TB_MAX  = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        InstrWrite;
  logic [31:0] WriteInst;
  logic [31:0] WriteAdress;
  logic        core_reset;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(TB_BASE), .MAX_WORDS(TB_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .InstrWrite  (InstrWrite),
    .WriteInst   (WriteInst),
    .WriteAdress (WriteAdress),
    .core_reset  (core_reset),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen on the memory port.
  always @(posedge clk) begin
    if (InstrWrite === 1'b1) begin
      got_addr.push_back(WriteAdress);
      got_data.push_back(WriteInst);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] v, input bit gaps);
    int n;
    n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.byte_data = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = v;
    while (bus.byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 100) else begin
      failures++;
      $error("FAIL ready_timeout observed=%0d expected=<100", n);
    end
    if (n < 100) @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
  endtask

  // Drive a whole image and compare the writes and final status with the model.
  task automatic run_load(input logic [15:0] len, input bit gaps, input bit use_w0,
                          input logic [31:0] w0, input bit bad_csum);
    logic [31:0] words[$];
    logic [31:0] w;
    logic [7:0]  xsum;
    logic [7:0]  bb;
    bit          exp_err;
    int          n;
    got_addr.delete();
    got_data.delete();
    pulse_start();
    check("ready_after_start", 32'(bus.byte_ready), 32'd0);
    exp_err = (32'(len) > TB_MAX);
    xsum    = len[7:0] ^ len[15:8];
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    if (!exp_err) begin
      for (int i = 0; i < int'(len); i++) begin
        w = (use_w0 && i == 0) ? w0 : $urandom;
        words.push_back(w);
        for (int j = 0; j < 4; j++) begin
          bb   = 8'(w >> (8 * j));
          xsum = xsum ^ bb;
          send_byte(bb, gaps);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_csum ? 8'(xsum + 8'd1) : xsum, gaps);
      exp_err = bad_csum;
`else
      if (len != 16'd0) begin
        check("strobe_early", 32'(InstrWrite), 32'd0);
        @(negedge clk);
        check("strobe_t1", 32'(InstrWrite), 32'd1);
        check("done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("done_t2", 32'(done), 32'd1);
        check("core_reset_t2", 32'(core_reset), 32'd0);
      end else begin
        check("zero_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
      end
`endif
    end
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 50) else begin
      failures++;
      $error("FAIL finish_timeout observed=%0d expected=<50", n);
    end
    @(negedge clk);
    check("done", 32'(done), 32'(!exp_err));
    check("error", 32'(error), 32'(exp_err));
    check("core_reset", 32'(core_reset), 32'(exp_err));
    check("ready_idle", 32'(bus.byte_ready), 32'd0);
    check("strobe_count", 32'(got_addr.size()), 32'(words.size()));
    for (int i = 0; i < words.size() && i < got_addr.size(); i++) begin
      check("write_addr", got_addr[i], TB_BASE + 32'(4 * i));
      check("write_data", got_data[i], words[i]);
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values while reset is held
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_strobe", 32'(InstrWrite), 32'd0);
    check("rst_inst", WriteInst, 32'd0);
    check("rst_addr", WriteAdress, TB_BASE);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Reference image 01 00 13 05 10 00
    run_load(16'd1, 1'b0, 1'b1, 32'h00100513, 1'b0);
    check("ref_word", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'h00100513);

    // Three words with random valid gaps
    run_load(16'd3, 1'b1, 1'b0, 32'h0, 1'b0);

    // Empty image
    run_load(16'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Oversized count is rejected, then a valid reload recovers
    run_load(16'd5, 1'b0, 1'b0, 32'h0, 1'b0);
    run_load(16'd1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of word 0 discards it
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
    check("mid_rst_strobe", 32'(InstrWrite), 32'd0);
    check("mid_rst_inst", WriteInst, 32'd0);
    check("mid_rst_addr", WriteAdress, TB_BASE);
    check("mid_rst_core_reset", 32'(core_reset), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_write", 32'(got_addr.size()), 32'd0);
    run_load(16'd2, 1'b0, 1'b0, 32'h0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: writes stay, load is rejected
    run_load(16'd1, 1'b0, 1'b1, 32'h00100513, 1'b1);
`endif

    // Random images, some oversized, some with corrupted checksums
    for (int it = 0; it < 8; it++) begin
      run_load(16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b0, 32'h0,
               ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
